// File: rtl/psram_burst_core.sv
// Octal PSRAM burst engine: CE setup, command, DDR address, latency, DDR data, CE hold/recovery.
// Reads capture on every synchronised DQS edge; a silent DQS aborts the read with an error flag.
module psram_burst_core #(
  parameter int DATA_BYTES = 8,
  parameter int ADDR_BYTES = 4,
  parameter int RD_TMO     = 255,
  parameter int LEN_W      = $clog2(DATA_BYTES+1)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [7:0]              cfg_div_i,
  input  logic [7:0]              cfg_wcmd_i,
  input  logic [7:0]              cfg_rcmd_i,
  input  logic [7:0]              cfg_wlc_i,
  input  logic [7:0]              cfg_rlc_i,
  input  logic [7:0]              cfg_tcsp_i,
  input  logic [7:0]              cfg_tchd_i,
  input  logic [7:0]              cfg_recy_i,
  input  logic                    xfer_valid_i,
  output logic                    xfer_ready_o,
  input  logic                    xfer_rdwr_i,
  input  logic [LEN_W-1:0]        xfer_len_i,
  input  logic [8*ADDR_BYTES-1:0] xfer_addr_i,
  input  logic [8*DATA_BYTES-1:0] xfer_wr_data_i,
  input  logic [DATA_BYTES-1:0]   xfer_wr_mask_i,
  output logic [8*DATA_BYTES-1:0] xfer_rd_data_o,
  output logic                    xfer_done_o,
  output logic                    xfer_err_o,
  output logic                    psram_sck_o,
  output logic                    psram_ce_o,
  output logic [7:0]              psram_io_en_o,
  output logic [7:0]              psram_io_out_o,
  input  logic [7:0]              psram_io_in_i,
  output logic                    psram_dqs_en_o,
  output logic                    psram_dqs_out_o,
  input  logic                    psram_dqs_in_i
);

  localparam int DW    = 8*DATA_BYTES;
  localparam int AW    = 8*ADDR_BYTES;
  localparam int TMO_W = $clog2(RD_TMO+1);

  typedef enum logic [3:0] {
    S_IDLE, S_TCSP, S_INST, S_ADDR, S_LATN, S_WDATA, S_RDATA, S_TCHD, S_RECY
  } state_t;

  state_t               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [8:0]           ph_q, ph_d;
  logic                 sck_q, sck_d;
  logic [7:0]           div_q, div_d;
  logic [7:0]           cmd_q, cmd_d;
  logic [7:0]           lc_q, lc_d;
  logic [7:0]           tcsp_q, tcsp_d, tchd_q, tchd_d, recy_q, recy_d;
  logic                 rdwr_q, rdwr_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [DW-1:0]        wdat_q, wdat_d;
  logic [DATA_BYTES-1:0] mask_q, mask_d;
  logic [DW-1:0]        rd_q, rd_d;
  logic                 err_q, err_d;
  logic [LEN_W-1:0]     rcnt_q, rcnt_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic                 fin_q, fin_d;
  logic [7:0]           io_s1_q, io_s2_q;
  logic                 dqs_s1_q, dqs_s2_q, dqs_s3_q;

  logic half_tick, dqs_edge, cap, rd_last, tmo_hit, lat_end;

  assign half_tick = (cnt_q == div_q);
  assign dqs_edge  = dqs_s2_q ^ dqs_s3_q;
  assign cap       = (state_q == S_RDATA) && dqs_edge && !fin_q;
  assign rd_last   = cap && (rcnt_q == len_q - LEN_W'(1));
  assign tmo_hit   = (state_q == S_RDATA) && !dqs_edge && !fin_q && (tmo_q == TMO_W'(RD_TMO-1));
  assign lat_end   = (ph_q == ({1'b0, lc_q} << 1) - 9'd1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ph_d    = ph_q;
    sck_d   = sck_q;
    div_d   = div_q;
    cmd_d   = cmd_q;
    lc_d    = lc_q;
    tcsp_d  = tcsp_q;
    tchd_d  = tchd_q;
    recy_d  = recy_q;
    rdwr_d  = rdwr_q;
    len_d   = len_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    mask_d  = mask_q;
    rd_d    = rd_q;
    err_d   = err_q;
    rcnt_d  = rcnt_q;
    tmo_d   = '0;
    fin_d   = fin_q;

    // Divider and SCK run only while the clocked phases are active.
    if (state_q inside {S_INST, S_ADDR, S_LATN, S_WDATA, S_RDATA}) begin
      cnt_d = half_tick ? 8'd0 : cnt_q + 8'd1;
      if (half_tick) begin
        sck_d = ~sck_q;
        ph_d  = ph_q + 9'd1;
      end
    end

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        sck_d = 1'b0;
        if (xfer_valid_i) begin
          state_d = S_TCSP;
          div_d   = (cfg_div_i == 8'd0) ? 8'd1 : cfg_div_i;
          cmd_d   = xfer_rdwr_i ? cfg_rcmd_i : cfg_wcmd_i;
          lc_d    = xfer_rdwr_i ? cfg_rlc_i : cfg_wlc_i;
          tcsp_d  = cfg_tcsp_i;
          tchd_d  = cfg_tchd_i;
          recy_d  = cfg_recy_i;
          rdwr_d  = xfer_rdwr_i;
          len_d   = (xfer_len_i == '0 || xfer_len_i > LEN_W'(DATA_BYTES)) ?
                    LEN_W'(DATA_BYTES) : xfer_len_i;
          addr_d  = xfer_addr_i;
          wdat_d  = xfer_wr_data_i;
          mask_d  = xfer_wr_mask_i;
          rd_d    = '0;
          err_d   = 1'b0;
          rcnt_d  = '0;
          fin_d   = 1'b0;
        end
      end
      S_TCSP: begin
        if (cnt_q == tcsp_q) begin
          state_d = S_INST;
          cnt_d   = '0;
          ph_d    = '0;
          sck_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_INST: begin
        if (half_tick && ph_q == 9'd1) begin
          state_d = S_ADDR;
          ph_d    = '0;
        end
      end
      S_ADDR: begin
        if (half_tick) begin
          addr_d = addr_q << 8;
          if (ph_q == 9'(ADDR_BYTES-1)) begin
            ph_d    = '0;
            state_d = (lc_q != 8'd0) ? S_LATN : (rdwr_q ? S_RDATA : S_WDATA);
          end
        end
      end
      S_LATN: begin
        if (half_tick && lat_end) begin
          ph_d    = '0;
          state_d = rdwr_q ? S_RDATA : S_WDATA;
        end
      end
      S_WDATA: begin
        if (half_tick) begin
          wdat_d = wdat_q << 8;
          mask_d = mask_q << 1;
          if (ph_q == 9'(len_q) - 9'd1) begin
            state_d = S_TCHD;
            cnt_d   = '0;
            sck_d   = 1'b0;
          end
        end
      end
      S_RDATA: begin
        tmo_d = dqs_edge ? '0 : tmo_q + TMO_W'(1);
        if (cap) begin
          rcnt_d = rcnt_q + LEN_W'(1);
          for (int i = 0; i < DATA_BYTES; i++)
            if (rcnt_q == LEN_W'(i)) rd_d[8*(DATA_BYTES-1-i) +: 8] = io_s2_q;
        end
        if (tmo_hit) err_d = 1'b1;
        // A finishing read waits for a falling SCK so the last high phase is never cut short.
        if (rd_last || tmo_hit || fin_q) begin
          if (!sck_q || half_tick) begin
            state_d = S_TCHD;
            cnt_d   = '0;
            sck_d   = 1'b0;
            fin_d   = 1'b0;
          end else begin
            fin_d = 1'b1;
          end
        end
      end
      S_TCHD: begin
        sck_d = 1'b0;
        if (cnt_q == tchd_q) begin
          state_d = S_RECY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RECY: begin
        if (cnt_q == recy_q) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      ph_q     <= '0;
      sck_q    <= 1'b0;
      div_q    <= 8'd1;
      cmd_q    <= '0;
      lc_q     <= '0;
      tcsp_q   <= '0;
      tchd_q   <= '0;
      recy_q   <= '0;
      rdwr_q   <= 1'b0;
      len_q    <= '0;
      addr_q   <= '0;
      wdat_q   <= '0;
      mask_q   <= '0;
      rd_q     <= '0;
      err_q    <= 1'b0;
      rcnt_q   <= '0;
      tmo_q    <= '0;
      fin_q    <= 1'b0;
      io_s1_q  <= '0;
      io_s2_q  <= '0;
      dqs_s1_q <= 1'b0;
      dqs_s2_q <= 1'b0;
      dqs_s3_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ph_q     <= ph_d;
      sck_q    <= sck_d;
      div_q    <= div_d;
      cmd_q    <= cmd_d;
      lc_q     <= lc_d;
      tcsp_q   <= tcsp_d;
      tchd_q   <= tchd_d;
      recy_q   <= recy_d;
      rdwr_q   <= rdwr_d;
      len_q    <= len_d;
      addr_q   <= addr_d;
      wdat_q   <= wdat_d;
      mask_q   <= mask_d;
      rd_q     <= rd_d;
      err_q    <= err_d;
      rcnt_q   <= rcnt_d;
      tmo_q    <= tmo_d;
      fin_q    <= fin_d;
      io_s1_q  <= psram_io_in_i;
      io_s2_q  <= io_s1_q;
      dqs_s1_q <= psram_dqs_in_i;
      dqs_s2_q <= dqs_s1_q;
      dqs_s3_q <= dqs_s2_q;
    end
  end

  always_comb begin
    psram_io_out_o = 8'd0;
    case (state_q)
      S_INST:  psram_io_out_o = cmd_q;
      S_ADDR:  psram_io_out_o = addr_q[AW-1 -: 8];
      S_WDATA: psram_io_out_o = wdat_q[DW-1 -: 8];
      default: psram_io_out_o = 8'd0;
    endcase
  end

  assign xfer_ready_o    = (state_q == S_IDLE);
  assign xfer_done_o     = (state_q == S_RECY) && (cnt_q == recy_q);
  assign xfer_err_o      = err_q;
  assign xfer_rd_data_o  = rd_q;
  assign psram_sck_o     = sck_q;
  assign psram_ce_o      = (state_q == S_IDLE) || (state_q == S_RECY);
  assign psram_io_en_o   = {8{state_q inside {S_INST, S_ADDR, S_LATN, S_WDATA}}};
  assign psram_dqs_en_o  = (state_q == S_WDATA);
  assign psram_dqs_out_o = (state_q == S_WDATA) && !mask_q[DATA_BYTES-1];

endmodule

// File: tb/tb_psram_burst_core.sv
// Directed bench for psram_burst_core: each burst is traced per clk cycle (cycle 0 = accept cycle),
// then checked against hand-computed cycle positions and values.
module tb_psram_burst_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  cfg_div, cfg_wcmd, cfg_rcmd, cfg_wlc, cfg_rlc, cfg_tcsp, cfg_tchd, cfg_recy;
  logic        xfer_valid, xfer_ready, xfer_rdwr;
  logic [3:0]  xfer_len;
  logic [31:0] xfer_addr;
  logic [63:0] xfer_wr_data, xfer_rd_data;
  logic [7:0]  xfer_wr_mask;
  logic        xfer_done, xfer_err;
  logic        sck, ce, dqs_en, dqs_out;
  logic [7:0]  io_en, io_out;
  logic [7:0]  io_pin;
  logic        dqs_pin;

  psram_burst_core dut (
    .clk_i(clk), .rst_i(rst),
    .cfg_div_i(cfg_div), .cfg_wcmd_i(cfg_wcmd), .cfg_rcmd_i(cfg_rcmd),
    .cfg_wlc_i(cfg_wlc), .cfg_rlc_i(cfg_rlc),
    .cfg_tcsp_i(cfg_tcsp), .cfg_tchd_i(cfg_tchd), .cfg_recy_i(cfg_recy),
    .xfer_valid_i(xfer_valid), .xfer_ready_o(xfer_ready), .xfer_rdwr_i(xfer_rdwr),
    .xfer_len_i(xfer_len), .xfer_addr_i(xfer_addr), .xfer_wr_data_i(xfer_wr_data),
    .xfer_wr_mask_i(xfer_wr_mask), .xfer_rd_data_o(xfer_rd_data),
    .xfer_done_o(xfer_done), .xfer_err_o(xfer_err),
    .psram_sck_o(sck), .psram_ce_o(ce), .psram_io_en_o(io_en), .psram_io_out_o(io_out),
    .psram_io_in_i(io_pin), .psram_dqs_en_o(dqs_en), .psram_dqs_out_o(dqs_out),
    .psram_dqs_in_i(dqs_pin)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic        t_sck[0:299], t_ce[0:299], t_ioen[0:299], t_dqsen[0:299], t_dqso[0:299];
  logic        t_done[0:299], t_rdy[0:299], t_err[0:299];
  logic [7:0]  t_io[0:299];
  logic [63:0] t_rd[0:299];
  int          drv_cyc[$];
  logic [7:0]  drv_byte[$];
  int          rst_at;
  logic [7:0]  div_late;
  logic [63:0] wd;
  logic [31:0] ad;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Samples cycle k at its negedge, then applies that cycle's stimulus.
  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      t_sck[k] = sck;  t_ce[k] = ce;  t_ioen[k] = io_en[0];  t_io[k] = io_out;
      t_dqsen[k] = dqs_en;  t_dqso[k] = dqs_out;  t_done[k] = xfer_done;
      t_rdy[k] = xfer_ready;  t_err[k] = xfer_err;  t_rd[k] = xfer_rd_data;
      xfer_valid = (k == 0);
      rst = (k == rst_at);
      if (k == 2) cfg_div = div_late;
      if (drv_cyc.size() > 0 && drv_cyc[0] == k) begin
        dqs_pin = ~dqs_pin;
        io_pin  = drv_byte[0];
        void'(drv_cyc.pop_front());
        void'(drv_byte.pop_front());
      end
    end
  endtask

  function automatic int ndone(input int n);
    int c = 0;
    for (int k = 0; k < n; k++) c += int'(t_done[k]);
    return c;
  endfunction

  initial begin
    rst = 1'b1;  xfer_valid = 1'b0;  xfer_rdwr = 1'b0;  xfer_len = 4'd8;
    cfg_div = 8'd1;  div_late = 8'd1;  cfg_wcmd = 8'hA0;  cfg_rcmd = 8'hEE;
    cfg_wlc = 8'd2;  cfg_rlc = 8'd1;  cfg_tcsp = 8'd0;  cfg_tchd = 8'd0;  cfg_recy = 8'd0;
    xfer_addr = 32'h1234_5678;  xfer_wr_data = 64'h1122_3344_5566_7788;  xfer_wr_mask = 8'hFF;
    io_pin = 8'h00;  dqs_pin = 1'b0;  rst_at = -1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ce", ce, 1'b1);
    chk("rst_sck", sck, 1'b0);
    chk("rst_ready", xfer_ready, 1'b1);
    chk("rst_io_en", io_en, 8'h00);
    chk("rst_io_out", io_out, 8'h00);
    chk("rst_dqs", {dqs_en, dqs_out}, 2'b00);
    chk("rst_done_err", {xfer_done, xfer_err}, 2'b00);
    chk("rst_rd_data", xfer_rd_data, 64'h0);

    // Full write, H=2, wlc=2, len=8.
    wd = xfer_wr_data;  ad = xfer_addr;
    run(42);
    chk("w_ready0", t_rdy[0], 1'b1);
    chk("w_ce1", t_ce[1], 1'b0);
    chk("w_sck1", t_sck[1], 1'b0);
    for (int k = 2; k < 38; k++) chk($sformatf("w_sck%0d", k), t_sck[k], ((k-2)/2) % 2 == 0);
    for (int k = 2; k < 6; k++) chk($sformatf("w_cmd%0d", k), t_io[k], 8'hA0);
    for (int i = 0; i < 4; i++) chk($sformatf("w_addr%0d", i), t_io[6+2*i], ad[31-8*i -: 8]);
    chk("w_latn14", t_io[14], 8'h00);
    chk("w_latn21", t_io[21], 8'h00);
    for (int i = 0; i < 8; i++) chk($sformatf("w_data%0d", i), t_io[23+2*i], wd[63-8*i -: 8]);
    chk("w_ioen2", t_ioen[2], 1'b1);
    chk("w_ioen37", t_ioen[37], 1'b1);
    chk("w_ioen38", t_ioen[38], 1'b0);
    chk("w_dqsen21", t_dqsen[21], 1'b0);
    chk("w_dqsen22", t_dqsen[22], 1'b1);
    chk("w_dqsen38", t_dqsen[38], 1'b0);
    chk("w_dqso22", t_dqso[22], 1'b0);
    chk("w_sck38", t_sck[38], 1'b0);
    chk("w_ce38", t_ce[38], 1'b0);
    chk("w_ce39", t_ce[39], 1'b1);
    chk("w_done39", t_done[39], 1'b1);
    chk("w_ndone", 64'(ndone(42)), 64'd1);
    chk("w_ready39", t_rdy[39], 1'b0);
    chk("w_ready40", t_rdy[40], 1'b1);

    // Masked write, len=3: only the first and third bytes are written.
    xfer_len = 4'd3;  xfer_wr_mask = 8'b1010_0000;  xfer_wr_data = 64'hC1C2_C3C4_C5C6_C7C8;
    run(32);
    chk("m_dqso22", t_dqso[22], 1'b0);
    chk("m_dqso24", t_dqso[24], 1'b1);
    chk("m_dqso26", t_dqso[26], 1'b0);
    chk("m_byte2", t_io[26], 8'hC3);
    chk("m_dqsen27", t_dqsen[27], 1'b1);
    chk("m_dqsen28", t_dqsen[28], 1'b0);
    chk("m_done29", t_done[29], 1'b1);
    chk("m_ndone", 64'(ndone(32)), 64'd1);

    // Read len=4, rlc=1: RDATA from cycle 18; each toggle is seen two cycles later.
    xfer_rdwr = 1'b1;  xfer_len = 4'd4;
    drv_cyc = '{18, 20, 22, 24};  drv_byte = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    run(34);
    chk("r_cmd", t_io[2], 8'hEE);
    chk("r_latn16", t_io[16], 8'h00);
    chk("r_ioen17", t_ioen[17], 1'b1);
    chk("r_ioen18", t_ioen[18], 1'b0);
    chk("r_dqsen18", t_dqsen[18], 1'b0);
    chk("r_sck28", t_sck[28], 1'b0);
    chk("r_done29", t_done[29], 1'b1);
    chk("r_ndone", 64'(ndone(34)), 64'd1);
    chk("r_data", t_rd[29], 64'hA1B2_C3D4_0000_0000);
    chk("r_err", t_err[29], 1'b0);
    chk("r_hold", t_rd[33], 64'hA1B2_C3D4_0000_0000);
    chk("r_ready30", t_rdy[30], 1'b1);

    // Timeout: two bytes (edges seen at 20 and 22), then 255 silent cycles 23..277.
    xfer_len = 4'd8;
    drv_cyc = '{18, 20};  drv_byte = '{8'h5A, 8'hC3};
    run(284);
    chk("t_clear", t_rd[1], 64'h0);
    chk("t_err1", t_err[1], 1'b0);
    chk("t_ce278", t_ce[278], 1'b0);
    chk("t_done278", t_done[278], 1'b0);
    chk("t_done279", t_done[279], 1'b1);
    chk("t_ndone", 64'(ndone(284)), 64'd1);
    chk("t_err", t_err[279], 1'b1);
    chk("t_data", t_rd[279], 64'h5AC3_0000_0000_0000);
    chk("t_ready280", t_rdy[280], 1'b1);

    // Reset during WDATA.
    xfer_rdwr = 1'b0;  xfer_len = 4'd8;  xfer_wr_mask = 8'hFF;  rst_at = 25;
    run(45);
    rst_at = -1;
    chk("x_ce24", t_ce[24], 1'b0);
    chk("x_ce26", t_ce[26], 1'b1);
    chk("x_sck26", t_sck[26], 1'b0);
    chk("x_ready26", t_rdy[26], 1'b1);
    chk("x_ioen26", t_ioen[26], 1'b0);
    chk("x_dqsen26", t_dqsen[26], 1'b0);
    chk("x_io26", t_io[26], 8'h00);
    chk("x_ndone", 64'(ndone(45)), 64'd0);

    // Divider 3 (H=4), len=0 means 8 bytes; tcsp=1, tchd=1, recy=2; cfg_div changed mid-burst.
    cfg_div = 8'd3;  div_late = 8'd0;  xfer_len = 4'd0;
    cfg_tcsp = 8'd1;  cfg_tchd = 8'd1;  cfg_recy = 8'd2;
    xfer_wr_data = 64'hD0D1_D2D3_D4D5_D6D7;
    run(82);
    chk("d_ce2", t_ce[2], 1'b0);
    chk("d_sck2", t_sck[2], 1'b0);
    chk("d_sck3", t_sck[3], 1'b1);
    chk("d_sck6", t_sck[6], 1'b1);
    chk("d_sck7", t_sck[7], 1'b0);
    chk("d_sck11", t_sck[11], 1'b1);
    chk("d_cmd10", t_io[10], 8'hA0);
    chk("d_addr0", t_io[11], 8'h12);
    chk("d_data0", t_io[46], 8'hD0);
    chk("d_data1", t_io[47], 8'hD1);
    chk("d_data7", t_io[74], 8'hD7);
    chk("d_dqsen74", t_dqsen[74], 1'b1);
    chk("d_dqsen75", t_dqsen[75], 1'b0);
    chk("d_sck75", t_sck[75], 1'b0);
    chk("d_ce76", t_ce[76], 1'b0);
    chk("d_ce77", t_ce[77], 1'b1);
    chk("d_done78", t_done[78], 1'b0);
    chk("d_done79", t_done[79], 1'b1);
    chk("d_ndone", 64'(ndone(82)), 64'd1);
    chk("d_ready80", t_rdy[80], 1'b1);

    // cfg_div=0 acts as 1; wlc=0 skips latency; len=1.
    cfg_div = 8'd0;  div_late = 8'd0;  cfg_wlc = 8'd0;  xfer_len = 4'd1;
    cfg_tcsp = 8'd0;  cfg_tchd = 8'd0;  cfg_recy = 8'd0;
    run(20);
    chk("z_sck3", t_sck[3], 1'b1);
    chk("z_sck4", t_sck[4], 1'b0);
    chk("z_sck6", t_sck[6], 1'b1);
    chk("z_addr3", t_io[13], 8'h78);
    chk("z_data0", t_io[14], 8'hD0);
    chk("z_dqsen15", t_dqsen[15], 1'b1);
    chk("z_dqsen16", t_dqsen[16], 1'b0);
    chk("z_done17", t_done[17], 1'b1);
    chk("z_ndone", 64'(ndone(20)), 64'd1);
    chk("z_ready18", t_rdy[18], 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
